// File: rtl/ghost_scheduler_if.sv
// ghost_scheduler_if: groups the game-flow inputs and the status/enable outputs
// of the ghost scheduler. The master modport drives the inputs (game FSM /
// frame timing side). The slave modport is the scheduler itself.
interface ghost_scheduler_if;
    logic        frame_tick;
    logic        start;
    logic [3:0]  got_hit;
    logic [3:0]  ghost_en;
    logic        ghost_rst;
    logic        hit_pulse;
    logic [1:0]  hit_id;
    logic [1:0]  lives;
    logic        invuln;
    logic [1:0]  state;
    logic        game_over;
    logic [15:0] score;

    modport master (
        output frame_tick, start, got_hit,
        input  ghost_en, ghost_rst, hit_pulse, hit_id, lives,
        input  invuln, state, game_over, score
    );

    modport slave (
        input  frame_tick, start, got_hit,
        output ghost_en, ghost_rst, hit_pulse, hit_id, lives,
        output invuln, state, game_over, score
    );
endinterface

// File: rtl/ghost_scheduler.sv
// ghost_scheduler: game-flow controller for the four ghost chasers.
// It activates ghosts over time and arbitrates their hit flags. It also tracks
// lives, the post-hit invulnerability window and game-over.
// Optional feature macro: GHOST_SCHED_SCORE_EN. When it is defined, a saturating
// survival score counts frame ticks in PLAY/HIT. When it is undefined, score is
// tied to zero.
module ghost_scheduler #(
    parameter logic [9:0] SPAWN_TICKS  = 10'd300,
    parameter logic [9:0] INVULN_TICKS = 10'd120,
    parameter logic [1:0] START_LIVES  = 2'd3
) (
    input  logic              clk,
    input  logic              rst,
    ghost_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ghost_en_q, ghost_en_d;
    logic        ghost_rst_q, ghost_rst_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic [1:0]  hit_id_q, hit_id_d;
    logic [1:0]  lives_q, lives_d;
    logic        invuln_q;
    logic        game_over_q;
    logic [9:0]  spawn_cnt_q, spawn_cnt_d;
    logic [9:0]  inv_cnt_q, inv_cnt_d;

    logic [3:0]  hit_vec_s;
    logic        init_s;
    logic [9:0]  spawn_cnt_tick_s;
    logic [3:0]  ghost_en_tick_s;

    // Lowest set bit wins when several ghosts overlap in the same cycle.
    function automatic logic [1:0] lowest_index(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0]) begin
            idx = 2'd0;
        end else if (v[1]) begin
            idx = 2'd1;
        end else if (v[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    assign hit_vec_s = bus.got_hit & ghost_en_q;
    assign init_s    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_OVER));

    // Spawn counter advance for a counted frame tick (no hit accepted that cycle).
    always_comb begin
        spawn_cnt_tick_s = spawn_cnt_q;
        ghost_en_tick_s  = ghost_en_q;
        if (ghost_en_q == 4'b1111) begin
            spawn_cnt_tick_s = 10'd0;
        end else if (spawn_cnt_q == (SPAWN_TICKS - 10'd1)) begin
            ghost_en_tick_s  = {ghost_en_q[2:0], 1'b1};
            spawn_cnt_tick_s = 10'd0;
        end else begin
            spawn_cnt_tick_s = spawn_cnt_q + 10'd1;
        end
    end

    // Next-state and next-output logic of the game-flow FSM.
    always_comb begin
        state_d     = state_q;
        ghost_en_d  = ghost_en_q;
        ghost_rst_d = 1'b0;
        hit_pulse_d = 1'b0;
        hit_id_d    = hit_id_q;
        lives_d     = lives_q;
        spawn_cnt_d = spawn_cnt_q;
        inv_cnt_d   = inv_cnt_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (init_s) begin
                    state_d     = ST_PLAY;
                    ghost_en_d  = 4'b0001;
                    lives_d     = START_LIVES;
                    spawn_cnt_d = 10'd0;
                    ghost_rst_d = 1'b1;
                end else begin
                    ghost_en_d = 4'b0000;
                    if (state_q == ST_OVER) begin
                        lives_d = 2'd0;
                    end else begin
                        lives_d = lives_q;
                    end
                end
            end
            ST_PLAY: begin
                if (|hit_vec_s) begin
                    hit_id_d    = lowest_index(hit_vec_s);
                    hit_pulse_d = 1'b1;
                    lives_d     = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d    = ST_OVER;
                        ghost_en_d = 4'b0000;
                    end else begin
                        state_d     = ST_HIT;
                        inv_cnt_d   = INVULN_TICKS;
                        ghost_rst_d = 1'b1;
                    end
                end else if (bus.frame_tick) begin
                    spawn_cnt_d = spawn_cnt_tick_s;
                    ghost_en_d  = ghost_en_tick_s;
                end else begin
                    spawn_cnt_d = spawn_cnt_q;
                end
            end
            ST_HIT: begin
                if (bus.frame_tick) begin
                    spawn_cnt_d = spawn_cnt_tick_s;
                    ghost_en_d  = ghost_en_tick_s;
                    inv_cnt_d   = inv_cnt_q - 10'd1;
                    if (inv_cnt_q == 10'd1) begin
                        state_d = ST_PLAY;
                    end else begin
                        state_d = ST_HIT;
                    end
                end else begin
                    inv_cnt_d = inv_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ghost_en_d = 4'b0000;
            end
        endcase
    end

    // FSM state and registered outputs; invuln/game_over follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ghost_en_q  <= 4'b0000;
            ghost_rst_q <= 1'b0;
            hit_pulse_q <= 1'b0;
            hit_id_q    <= 2'd0;
            lives_q     <= START_LIVES;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
            spawn_cnt_q <= 10'd0;
            inv_cnt_q   <= 10'd0;
        end else begin
            state_q     <= state_d;
            ghost_en_q  <= ghost_en_d;
            ghost_rst_q <= ghost_rst_d;
            hit_pulse_q <= hit_pulse_d;
            hit_id_q    <= hit_id_d;
            lives_q     <= lives_d;
            invuln_q    <= (state_d == ST_HIT);
            game_over_q <= (state_d == ST_OVER);
            spawn_cnt_q <= spawn_cnt_d;
            inv_cnt_q   <= inv_cnt_d;
        end
    end

`ifdef GHOST_SCHED_SCORE_EN
    logic [15:0] score_q, score_d;

    // Survival score: counts frame ticks in PLAY/HIT, saturates, clears on start.
    always_comb begin
        score_d = score_q;
        if (init_s) begin
            score_d = 16'd0;
        end else if (bus.frame_tick && ((state_q == ST_PLAY) || (state_q == ST_HIT))
                     && (score_q != 16'hFFFF)) begin
            score_d = score_q + 16'd1;
        end else begin
            score_d = score_q;
        end
    end

    // Score register.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = 16'd0;
`endif

    assign bus.ghost_en  = ghost_en_q;
    assign bus.ghost_rst = ghost_rst_q;
    assign bus.hit_pulse = hit_pulse_q;
    assign bus.hit_id    = hit_id_q;
    assign bus.lives     = lives_q;
    assign bus.invuln    = invuln_q;
    assign bus.state     = state_q;
    assign bus.game_over = game_over_q;

endmodule

// File: doc/ghost_scheduler.md
# ghost_scheduler

Game-flow controller for the ghost datapath. Decides which of the four ghost chasers are active and when. Consumes their per-ghost hit flags, arbitrates simultaneous hits, and maintains lives, the post-hit invulnerability window and game-over. Sits between the top-level game FSM/VGA frame timing and the ghost movement block:
- drives that block's per-ghost enables and its reset;
- feeds lives/state to the HUD and LED logic.

## Interface
Parameters:
- SPAWN_TICKS, 10'd300: frame ticks between successive ghost activations (1..1023).
- INVULN_TICKS, 10'd120: frame ticks of invulnerability after a hit (1..1023).
- START_LIVES, 2'd3: lives loaded on game start (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; all game-time counting uses it.
- start  in  1  level; begins/restarts a game from IDLE or OVER.
- got_hit  in  4  per-ghost overlap flags, bit0 = ghost1.
- ghost_en  out  4  per-ghost enable to the movement block.
- ghost_rst  out  1  one-cycle pulse; resets positions of enabled ghosts to their corners.
- hit_pulse  out  1  one-cycle pulse per accepted hit.
- hit_id  out  2  index of the last accepted hit (0 = ghost1).
- lives  out  2  remaining lives.
- invuln  out  1  high during HIT state.
- state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER.
- game_over  out  1  high in OVER.
- score  out  16  survival score (see Configuration).

## Operation
- All outputs are registered. Reset values:
  - state = IDLE;
  - ghost_en, ghost_rst, hit_pulse, hit_id, invuln, game_over, score = 0;
  - lives = START_LIVES.
- Internal counters: spawn_cnt[9:0] and inv_cnt[9:0]; both cleared by reset.
- IDLE:
  - ghost_en = 0.
  - On start: go to PLAY with ghost_en = 4'b0001, lives = START_LIVES, spawn_cnt = 0, score = 0, and a ghost_rst pulse.
- PLAY:
  - Hits: an accepted hit is any bit set in (got_hit & ghost_en).
    - Lowest set index wins. It is latched into hit_id; hit_pulse fires and lives decrements.
    - If lives was 1: lives becomes 0, go to OVER.
    - Otherwise: go to HIT, load inv_cnt = INVULN_TICKS and pulse ghost_rst.
  - Spawning: on each frame_tick with no accepted hit that cycle, spawn_cnt increments.
    - When spawn_cnt == SPAWN_TICKS-1 and ghost_en != 4'b1111: ghost_en <= {ghost_en[2:0],1'b1} and spawn_cnt = 0.
    - Once all four ghosts are enabled, spawn_cnt holds at 0.
- HIT:
  - invuln = 1; got_hit is ignored.
  - inv_cnt decrements on each frame_tick. At the tick where inv_cnt == 1, go to PLAY.
  - spawn_cnt keeps counting; a spawn in HIT behaves as in PLAY.
- OVER:
  - ghost_en = 0, game_over = 1, lives = 0.
  - start performs the same initialisation as from IDLE.
- start is ignored in PLAY and HIT.

## Timing
- got_hit sampled at edge N: hit_pulse, hit_id, lives, state and ghost_rst are valid after edge N+1. hit_pulse and ghost_rst are one cycle wide.
- start sampled at edge N: state = PLAY, ghost_en = 0001 and ghost_rst = 1 after edge N+1.
- Spawn: a new ghost_en bit rises 1 cycle after the SPAWN_TICKS-th frame_tick since the last spawn or game start.
- Invulnerability lasts exactly INVULN_TICKS frame_ticks. got_hit sampled in the same cycle as the state returns to PLAY is ignored; got_hit is re-armed from the next cycle.
- Simultaneous events:
  - Hit and spawn-due on the same tick: the hit wins; the spawn is deferred to the next frame_tick, with spawn_cnt held at SPAWN_TICKS-1.
  - Multiple got_hit bits: one hit, lowest index, one life lost.
  - frame_tick together with start in OVER: start wins; the tick is not counted.
- rst mid-game: all registers return to reset values on the next edge regardless of state. ghost_rst is not pulsed by rst.
- Disabled ghosts' got_hit bits never count.

## Configuration
- GHOST_SCHED_SCORE_EN defined:
  - score increments by 1 on every frame_tick in PLAY or HIT, saturating at 16'hFFFF.
  - score is held in OVER and cleared on start.
- GHOST_SCHED_SCORE_EN undefined: score is tied to 16'd0 and no counter logic is synthesised.

## Test plan
- Start/spawn:
  - Stimulus: SPAWN_TICKS=4; rst, then start, then 12 frame_ticks.
  - Required: ghost_en goes 0001, then 0011 after tick 4, 0111 after tick 8, 1111 after tick 12; it stays 1111 afterwards; one ghost_rst pulse at start.
- Hit arbitration:
  - Stimulus: ghost_en=0111; got_hit=4'b0110 for 1 cycle.
  - Required: one hit_pulse, hit_id=1, lives 3→2, state=HIT, invuln=1, ghost_rst pulse.
- Invulnerability:
  - Stimulus: INVULN_TICKS=3; got_hit held high through HIT.
  - Required: no further hit_pulse for 3 ticks. After the 3rd tick, state=PLAY; the next cycle with got_hit set gives hit_pulse and lives 2→1.
- Game over/restart:
  - Stimulus: START_LIVES=1; a single hit, then start.
  - Required: state=OVER, game_over=1, ghost_en=0, lives=0. After start: state=PLAY, lives=1, ghost_en=0001.
- Hit/spawn collision:
  - Stimulus: SPAWN_TICKS=2; hit on the same cycle as the 2nd frame_tick.
  - Required: ghost_en unchanged that cycle; the bit is added on the next frame_tick.
- Reset mid-HIT, with GHOST_SCHED_SCORE_EN defined:
  - Stimulus: assert rst during HIT.
  - Required: state=IDLE, lives=START_LIVES, score=0, no ghost_rst pulse.
  - Also: score counted 10 during 10 ticks of play before the rst.
